beep_rate_gen: RTL
==================

// Module: beep_rate_gen
// PURPOSE
//  Parametrised multi-channel beep-rate generator for the proximity alert path.
//  Each channel produces a square wave and a one-cycle tick at one of four selectable rates, with per-channel enable.
//  Rate changes apply glitch-free, only at whole-period boundaries. A global resync phase-aligns all running channels.
//  Sits between the distance-classifier (drives ch_sel/ch_en) and the buzzer/LED drivers (consume wave/tick).
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency, Hz
//  NUM_CH   4           number of independent channels (1..16)
//  RATE0_HZ 2           toggle rate for sel=0 (full periods per second)
//  RATE1_HZ 3           rate for sel=1
//  RATE2_HZ 4           rate for sel=2
//  RATE3_HZ 10          rate for sel=3
// PORTS
//  clk      in   1         system clock; all logic on posedge
//  rst_n    in   1         synchronous reset, active-low
//  ch_en    in   NUM_CH    per-channel enable; 0 = muted/idle
//  ch_sel   in   2*NUM_CH  per-channel rate select; bits [2i+1:2i] belong to channel i
//  resync   in   1         1-cycle pulse; restart all enabled channels in phase
//  wave     out  NUM_CH    per-channel square wave, 50% duty
//  tick     out  NUM_CH    1-cycle pulse on each wave 0->1 edge
//  active   out  NUM_CH    channel in RUN state
// BEHAVIOUR
//  - Clocking and reset: one clock; reset synchronous, active-low; while rst_n=0 every output is 0 and all counters/state are 0.
//  - Half period per rate k: HALF[k] = CLK_HZ / (2*RATEk_HZ), integer floor, HALF>=2 enforced at elaboration.
//  - Counter width: CNT_W = $clog2(max HALF).
//  - Per-channel FSM has two states, IDLE and RUN:
//    IDLE: wave=0, tick=0, active=0, cnt=0.
//     If ch_en=1 is sampled, the next cycle enters RUN with wave=1, tick=1, cnt=0, and cur_sel latched from ch_sel. Latency is 1 cycle.
//    RUN: cnt increments each cycle.
//     When cnt==HALF[cur_sel]-1: cnt<=0 and wave<=~wave.
//     On a 0->1 toggle, tick=1 for exactly that cycle.
//     cur_sel reloads from ch_sel only on the 0->1 toggle, i.e. whole-period boundary.
//     A mid-period ch_sel change never shortens or stretches the current period.
//    RUN with ch_en=0 sampled: the next cycle returns to IDLE (wave=0, tick=0), even mid-period.
//  - Exact period equals 2*HALF[cur_sel] cycles. There is no off-by-one: the count runs 0..HALF-1.
//  - resync=1: every channel with ch_en=1 behaves as if freshly enabled. Next cycle wave=1, tick=1, cnt=0, cur_sel reloaded.
//  - Priority: rst_n > ch_en=0 > resync > normal count.
//  - Simultaneous terminal count and ch_en fall: the fall wins and the channel goes IDLE.
//  - Reset mid-operation: all channels return to IDLE next cycle. No residual tick.
//  - Channels are fully independent. No shared counter, so phases drift only through differing enables.
// STRUCTURE
//  - Package beep_rate_pkg holds the RATE_SEL_W=2 constant, the ch_state_t enum {IDLE,RUN}, and a function half_period(clk_hz, rate_hz).
//  - Sub-module beep_rate_ch (one channel: FSM + counter + sel latch).
//    The top is a generate loop over NUM_CH plus parameter checks.
// TESTING (CLK_HZ=1000 -> HALF = 250,166,125,50)
//  1. Reset high 3 cycles then released, ch_en=0 -> wave/tick/active stay 0 for 1000 cycles.
//  2. ch0 en with sel=3 -> wave=1 and tick=1 at the cycle after en.
//     Wave falls 50 cycles later. Ticks repeat every 100 cycles.
//  3. ch0 sel=0, switched to sel=3 at cycle 100 (mid high phase).
//     The current period stays 500 cycles. The next period is 100 cycles.
//  4. ch1 sel=1 running, ch_en dropped at terminal count -> wave=0 next cycle.
//     No tick. Re-enable gives tick 1 cycle later.
//  5. 4 channels at sel 0..3 enabled at different times, then a resync pulse.
//     All wave/tick=1 on the same cycle. Each subsequent period is exact per sel.
//  6. rst_n=0 for 1 cycle mid-run on all channels -> all outputs 0 the next cycle.
//     active=0, and the channels restart only on a new ch_en sample.

Source files
------------

// File: rtl/beep_rate_pkg.sv
// Shared constants, channel state type and half-period helper for the
// multi-channel beep-rate generator.
package beep_rate_pkg;

    localparam int RATE_SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    // A zero rate yields 0 so the HALF>=2 elaboration check catches it.
    function automatic int half_period(input int clk_hz, input int rate_hz);
        if (rate_hz <= 0) begin
            return 0;
        end
        return clk_hz / (2 * rate_hz);
    endfunction

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/beep_rate_ch.sv
// One beep channel: IDLE/RUN FSM, half-period counter and a rate-select
// latch that only reloads on whole-period boundaries.
module beep_rate_ch
    import beep_rate_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int HALF0 = 250,
    parameter int HALF1 = 166,
    parameter int HALF2 = 125,
    parameter int HALF3 = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  resync,
    input  logic [RATE_SEL_W-1:0] sel,
    output logic                  wave,
    output logic                  tick,
    output logic                  active
);

    localparam logic [CNT_W-1:0] TERM0 = CNT_W'(HALF0 - 1);
    localparam logic [CNT_W-1:0] TERM1 = CNT_W'(HALF1 - 1);
    localparam logic [CNT_W-1:0] TERM2 = CNT_W'(HALF2 - 1);
    localparam logic [CNT_W-1:0] TERM3 = CNT_W'(HALF3 - 1);

    ch_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wave_q, wave_d;
    logic                  tick_q, tick_d;
    logic [RATE_SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]      term;

    always_comb begin
        case (sel_q)
            2'd0:    term = TERM0;
            2'd1:    term = TERM1;
            2'd2:    term = TERM2;
            default: term = TERM3;
        endcase
    end

    // Priority: disable, then (re)start on enable or resync, then counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wave_d  = wave_q;
        tick_d  = 1'b0;
        sel_d   = sel_q;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            wave_d  = 1'b0;
        end else if (state_q == IDLE || resync) begin
            state_d = RUN;
            cnt_d   = '0;
            wave_d  = 1'b1;
            tick_d  = 1'b1;
            sel_d   = sel;
        end else if (cnt_q == term) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
            if (!wave_q) begin
                tick_d = 1'b1;
                sel_d  = sel;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wave_q  <= 1'b0;
            tick_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wave_q  <= wave_d;
            tick_q  <= tick_d;
            sel_q   <= sel_d;
        end
    end

    assign wave   = wave_q;
    assign tick   = tick_q;
    assign active = (state_q == RUN);

endmodule

// File: rtl/beep_rate_gen.sv
// Multi-channel beep-rate generator: independent per-channel square wave
// and tick at one of four rates, with a global in-phase resync.
module beep_rate_gen
    import beep_rate_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int NUM_CH   = 4,
    parameter int RATE0_HZ = 2,
    parameter int RATE1_HZ = 3,
    parameter int RATE2_HZ = 4,
    parameter int RATE3_HZ = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [RATE_SEL_W*NUM_CH-1:0] ch_sel,
    input  logic                         resync,
    output logic [NUM_CH-1:0]            wave,
    output logic [NUM_CH-1:0]            tick,
    output logic [NUM_CH-1:0]            active
);

    localparam int HALF0    = half_period(CLK_HZ, RATE0_HZ);
    localparam int HALF1    = half_period(CLK_HZ, RATE1_HZ);
    localparam int HALF2    = half_period(CLK_HZ, RATE2_HZ);
    localparam int HALF3    = half_period(CLK_HZ, RATE3_HZ);
    localparam int HALF_MAX = max_of4(HALF0, HALF1, HALF2, HALF3);
    localparam int CNT_W    = $clog2(HALF_MAX);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("beep_rate_gen: NUM_CH must be 1..16");
    end

    if (HALF0 < 2 || HALF1 < 2 || HALF2 < 2 || HALF3 < 2) begin : g_bad_half
        $error("beep_rate_gen: every half period must be at least 2 clocks");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        beep_rate_ch #(
            .CNT_W (CNT_W),
            .HALF0 (HALF0),
            .HALF1 (HALF1),
            .HALF2 (HALF2),
            .HALF3 (HALF3)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (ch_en[i]),
            .resync (resync),
            .sel    (ch_sel[RATE_SEL_W*i +: RATE_SEL_W]),
            .wave   (wave[i]),
            .tick   (tick[i]),
            .active (active[i])
        );
    end

endmodule
